fft_cmult_combine: RTL

- Downstream consumer of the 8-cell shift-add multiplier chain in the FFT datapath.
- The chain produces unsigned, truncated 16-bit magnitude products. Upstream sequencing feeds the four real partial products of one complex multiply (B·W) through the chain in fixed order: rr, ii, ri, ir.
- This block restores each product's sign, combines the four into one complex product (re = rr − ii, im = ri + ir), rescales for the Q1.7 twiddle format, and presents it to the butterfly add/sub stage.

---
 rtl/fft_cmult_combine_pkg.sv | 24 ++
 rtl/fft_round_sat.sv | 36 +++
 rtl/fft_cmult_combine.sv | 119 +++++++++++
 3 files changed

// File: rtl/fft_cmult_combine_pkg.sv
// Shared FFT datapath definitions: default widths, combine-phase encoding
// and signed saturation bounds.
package fft_cmult_combine_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int OUT_W_DEF  = 16;
    localparam int SHIFT_DEF  = 7;

    typedef enum logic [1:0] {
        PH_RR = 2'd0,
        PH_II = 2'd1,
        PH_RI = 2'd2,
        PH_IR = 2'd3
    } phase_e;

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of one
// signed accumulator component down to OUT_W bits.
module fft_round_sat
    import fft_cmult_combine_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int SHIFT = SHIFT_DEF,
    parameter int ROUND = 1,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_W:0] RND =
        (ROUND != 0 && SHIFT > 0) ? ({{IN_W{1'b0}}, 1'b1} << RSH) : '0;

    // One guard bit so the rounding add cannot wrap at the accumulator extremes.
    logic signed [IN_W:0] v_s;
    logic signed [IN_W:0] shifted_s;

    // Round, shift, then clamp into the signed OUT_W range.
    always_comb begin
        v_s       = {din[IN_W-1], din} + RND;
        shifted_s = v_s >>> SHIFT;
        if (longint'(shifted_s) > sat_max(OUT_W)) begin
            dout = OUT_W'(sat_max(OUT_W));
        end else if (longint'(shifted_s) < sat_min(OUT_W)) begin
            dout = OUT_W'(sat_min(OUT_W));
        end else begin
            dout = shifted_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fft_cmult_combine.sv
// Restores signs of the four chain partial products (rr, ii, ri, ir), combines
// them into one complex product and rescales it for the butterfly stage.
module fft_cmult_combine
    import fft_cmult_combine_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int ROUND  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [PROD_W-1:0]       in_prod,
    input  logic                    in_sign,
    input  logic                    in_first,
    output logic                    out_vld,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic                    err
);

    localparam int ACC_W = PROD_W + 2;

    phase_e                  phase_r;
    logic signed [ACC_W-1:0] acc_re_r;
    logic signed [ACC_W-1:0] acc_im_r;
    logic                    done_r;
    logic signed [ACC_W-1:0] ext_s;
    logic signed [ACC_W-1:0] term_s;
    logic signed [OUT_W-1:0] re_sat_s;
    logic signed [OUT_W-1:0] im_sat_s;

    // Signed term from the unsigned magnitude and its side-band sign.
    always_comb begin
        ext_s = {2'b00, in_prod};
        if (in_sign) begin
            term_s = -ext_s;
        end else begin
            term_s = ext_s;
        end
    end

    fft_round_sat #(
        .IN_W  (ACC_W),
        .SHIFT (SHIFT),
        .ROUND (ROUND),
        .OUT_W (OUT_W)
    ) u_rs_re (
        .din  (acc_re_r),
        .dout (re_sat_s)
    );

    fft_round_sat #(
        .IN_W  (ACC_W),
        .SHIFT (SHIFT),
        .ROUND (ROUND),
        .OUT_W (OUT_W)
    ) u_rs_im (
        .din  (acc_im_r),
        .dout (im_sat_s)
    );

    // Phase sequencing, accumulation and registered outputs. An in_first
    // sample always restarts a group; in PH1..PH3 that is also a framing error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r  <= PH_RR;
            acc_re_r <= '0;
            acc_im_r <= '0;
            done_r   <= 1'b0;
            out_vld  <= 1'b0;
            out_re   <= '0;
            out_im   <= '0;
            err      <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            err     <= 1'b0;
            done_r  <= 1'b0;
            if (done_r) begin
                out_vld <= 1'b1;
                out_re  <= re_sat_s;
                out_im  <= im_sat_s;
            end
            if (in_vld) begin
                if (in_first) begin
                    acc_re_r <= term_s;
                    phase_r  <= PH_II;
                    if (phase_r != PH_RR) begin
                        err <= 1'b1;
                    end
                end else begin
                    case (phase_r)
                        PH_RR: begin
                            err <= 1'b1;
                        end
                        PH_II: begin
                            acc_re_r <= acc_re_r - term_s;
                            phase_r  <= PH_RI;
                        end
                        PH_RI: begin
                            acc_im_r <= term_s;
                            phase_r  <= PH_IR;
                        end
                        PH_IR: begin
                            acc_im_r <= acc_im_r + term_s;
                            phase_r  <= PH_RR;
                            done_r   <= 1'b1;
                        end
                        default: begin
                            phase_r <= PH_RR;
                        end
                    endcase
                end
            end
        end
    end

endmodule
